// File: rtl/seq_det_pkg.sv
// Shared state encoding for the 101/110 overlapping Moore detector.
// Encodings 3'd6 and 3'd7 are unused and recover to S_IDLE.
package seq_det_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_1    = 3'd1;
    localparam state_t S_10   = 3'd2;
    localparam state_t S_11   = 3'd3;
    localparam state_t S_101  = 3'd4;
    localparam state_t S_110  = 3'd5;

    // Detect-state set: the only states that raise the flag.
    function automatic logic is_detect(input state_t s);
        return (s == S_101) || (s == S_110);
    endfunction

endpackage

// File: rtl/seq_det_101_110_moore.sv
// Overlapping Moore detector for the serial patterns 101 and 110.
// The flag is decoded from the state register only; in never reaches out combinationally.
module seq_det_101_110_moore
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rstn,  // active-high synchronous reset despite the name
    input  logic in,
    output logic out
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each state names the longest suffix still useful toward a match.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = in ? S_1   : S_IDLE;
            S_1:     state_d = in ? S_11  : S_10;
            S_10:    state_d = in ? S_101 : S_IDLE;
            S_11:    state_d = in ? S_11  : S_110;
            S_101:   state_d = in ? S_11  : S_10;
            S_110:   state_d = in ? S_101 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out = is_detect(state_q);
    end

endmodule

// File: tb/tb_seq_det_101_110_moore.sv
// Self-checking bench for seq_det_101_110_moore: directed sequences plus a random
// soak against a three-bit sliding-window model of the input stream.
module tb_seq_det_101_110_moore;

    logic clk;
    logic rstn;
    logic in_b;
    logic out_b;

    int tests;
    int fails;
    logic [2:0] win;  // last three bits seen since reset, zero-filled after reset

    seq_det_101_110_moore dut (
        .clk  (clk),
        .rstn (rstn),
        .in   (in_b),
        .out  (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one clock with the given reset/input. Out is checked against the window
    // model and, when exp is 0 or 1, against an explicit expected value as well.
    task automatic step(input string tag, input logic r, input logic b, input int exp);
        logic mexp;
        rstn = r;
        in_b = b;
        @(posedge clk);
        if (r) win = 3'b000;
        else   win = {win[1:0], b};
        mexp = (win == 3'b101) || (win == 3'b110);
        #1;
        tests++;
        assert (out_b === mexp) else begin
            fails++;
            $error("FAIL %s model: observed %b expected %b", tag, out_b, mexp);
        end
        if (exp == 0 || exp == 1) begin
            tests++;
            assert (out_b === exp[0]) else begin
                fails++;
                $error("FAIL %s directed: observed %b expected %0d", tag, out_b, exp);
            end
        end
    endtask

    task automatic run_seq(input string tag, input logic [15:0] bits,
                           input logic [15:0] exps, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, bits[n-1-i], int'(exps[n-1-i]));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        win   = 3'b000;
        rstn  = 1'b1;
        in_b  = 1'b0;

        // Reset and idle
        step("reset0", 1'b1, 1'b1, 0);
        step("reset1", 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'b0, 0);

        // Single 101
        step("rst_a", 1'b1, 1'b0, 0);
        run_seq("seq_101", 16'b10100, 16'b00100, 5);

        // Run of ones then 110
        step("rst_b", 1'b1, 1'b0, 0);
        run_seq("seq_ones", 16'b111100, 16'b000010, 6);

        // Overlap chain: 110, 101, 101, 110
        step("rst_c", 1'b1, 1'b0, 0);
        run_seq("overlap", 16'b11010110, 16'b00110101, 8);

        // Reset on the edge that would complete 110
        step("rst_d", 1'b1, 1'b0, 0);
        run_seq("mid_a", 16'b11, 16'b00, 2);
        step("mid_a_rst", 1'b1, 1'b0, 0);
        step("mid_a_post0", 1'b0, 1'b0, 0);
        step("mid_a_post1", 1'b0, 1'b1, 0);
        step("mid_a_post2", 1'b0, 1'b1, 0);

        // Reset on the edge that would complete 101
        step("rst_e", 1'b1, 1'b0, 0);
        run_seq("mid_b", 16'b10, 16'b00, 2);
        step("mid_b_rst", 1'b1, 1'b1, 0);
        step("mid_b_post0", 1'b0, 1'b0, 0);
        step("mid_b_post1", 1'b0, 1'b1, 0);
        step("mid_b_post2", 1'b0, 1'b0, 0);

        // Random soak with occasional resets
        for (int i = 0; i < 500; i++) begin
            step("soak", ($urandom_range(0, 31) == 0), 1'($urandom), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_det_101_110_moore.md
Name: seq_det_101_110_moore

Overview:
- Moore FSM that detects the serial bit patterns 101 and 110 on a 1-bit input stream.
- Detection is overlapping: the trailing bits of one match can start the next match.
- Sits in the serial-protocol front end as a single-clock pattern flag generator.
- Output depends only on the registered state, never directly on the input.

Parameters:
- None. State encoding is fixed by package constants.

Ports:
- clk   input   1  rising-edge clock; all state changes occur on its rising edge
- rstn  input   1  synchronous reset, active-HIGH despite the name. rstn=1 at a rising clk edge resets the FSM.
- in    input   1  serial data bit, sampled on each rising clk edge
- out   output  1  detection flag; 1 while the FSM is in a detect state

Behaviour:
- Reset:
  - Synchronous, active-high. The one clock and the reset polarity/synchronicity are fixed; clock and reset are named clk and rstn.
  - If rstn=1 at a rising edge: state goes to S_IDLE and out=0 from that edge.
  - in is ignored on reset edges.
  - Reset overrides any transition, including mid-sequence or in a detect state.
- States, named by the suffix they track:
  - S_IDLE: no useful suffix
  - S_1: "1"
  - S_10: "10"
  - S_11: "11"
  - S_101: "101" detected
  - S_110: "110" detected
- Transitions (in=0 / in=1):
  - S_IDLE -> S_IDLE / S_1
  - S_1    -> S_10 / S_11
  - S_10   -> S_IDLE / S_101
  - S_11   -> S_110 / S_11
  - S_101  -> S_10 / S_11 (overlap on trailing "1"; "1010" keeps suffix "10")
  - S_110  -> S_IDLE / S_101 (overlap on trailing "10")
- Output decode:
  - out=1 iff state is S_101 or S_110; otherwise out=0.
  - Decode is purely from the state register, with no combinational path from in to out.
- Latency:
  - out rises right after the rising edge that samples the third bit of a match.
  - It holds for exactly one cycle unless the next bit completes another match.
- Back-to-back matches:
  - Consecutive matches give consecutive out=1 cycles with no gap.
  - Example: 1101 gives out=1 for two cycles (110 then 101).
- Unknown state: any unused encoding returns to S_IDLE on the next edge, with out=0 while in it.
- No handshake, no enable; one bit is consumed every clock.

Decomposition:
- Package seq_det_pkg holds:
  - state typedef (3-bit enum)
  - the six state constants
  - the detect-state set used by the output decode
- No sub-module. The block is one module with a state register, a next-state process and an output decode.

Test Plan:
- Reset and idle: rstn=1 for 2 edges, then rstn=0 with in held at 0 for 10 edges -> out=0 throughout.
- Single 101: after reset, in=1,0,1,0,0 -> out=1 only in the cycle after the 3rd edge, then 0.
- Single 110 and run of ones: in=1,1,1,1,0,0 -> out=0 during the ones, out=1 one cycle after the edge sampling the first 0, then 0.
- Overlap chain: in=1,1,0,1,0,1,1,0 -> out=1 after edges 3 (110), 4 (101), 6 (101) and 8 (110); out=0 after all other edges.
- Reset mid-operation:
  - in=1,1, then rstn=1 at the edge where in=0, then rstn=0 and in=0 -> no out pulse; state S_IDLE.
  - in=1,0,1 with rstn=1 at the 3rd edge -> out stays 0.
- Random soak: 500 random bits checked against a 3-bit shift-register reference model (match 101 or 110, window cleared on reset) -> out equals model flag delayed by the registered-output latency every cycle.
